// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS pipeline control blocks.
//   FWD_*        : operand-mux select codes driven into EX
//   REG_BITS_DFLT: default register-specifier width
//   idex_ent_t / wb_ent_t : shadow pipeline entry layouts at the default width
package mips_pkg;

  localparam int REG_BITS_DFLT = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB    = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM result

  typedef struct packed {
    logic [REG_BITS_DFLT-1:0] rs;
    logic [REG_BITS_DFLT-1:0] rt;
    logic [REG_BITS_DFLT-1:0] dst;
    logic                     regwrite;
    logic                     memread;
  } idex_ent_t;

  typedef struct packed {
    logic [REG_BITS_DFLT-1:0] dst;
    logic                     regwrite;
  } wb_ent_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority compare for one EX operand.
//   opr              : operand register specifier of the instruction in EX
//   exmem_dst/_rw    : EX/MEM shadow destination and regwrite
//   memwb_dst/_rw    : MEM/WB shadow destination and regwrite
//   sel              : FWD_EXMEM, FWD_WB or FWD_REG (11 never produced)
module fwd_select
  import mips_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DFLT
) (
  input  logic [REG_BITS-1:0] opr,
  input  logic [REG_BITS-1:0] exmem_dst,
  input  logic                exmem_rw,
  input  logic [REG_BITS-1:0] memwb_dst,
  input  logic                memwb_rw,
  output logic [1:0]          sel
);

  // The nearer producer wins; $0 is hardwired so a write to it never forwards.
  always_comb begin
    sel = FWD_REG;
    if (exmem_rw && (exmem_dst != '0) && (exmem_dst == opr))
      sel = FWD_EXMEM;
    else if (memwb_rw && (memwb_dst != '0) && (memwb_dst == opr))
      sel = FWD_WB;
  end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: forwarding and load-use hazard control for the 5-stage core.
// Keeps its own shadow of the ID/EX, EX/MEM and MEM/WB destination fields.
//   clk, rst                 : clock, async active-high reset
//   id_valid, id_rs, id_rt   : instruction in ID and its source registers
//   id_dst, id_regwrite      : its final destination and write enable
//   id_memread               : it is a load
//   flush                    : kill the ID instruction, bubble into EX
//   fwd_a, fwd_b             : EX operand mux selects
//   stall                    : load-use hazard, hold PC and IF/ID
//   stall_count              : saturating count of stall cycles
module forward_ctrl
  import mips_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DFLT,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_dst,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall,
  output logic [CNT_BITS-1:0] stall_count
);

  localparam int STAGES = 2;  // index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB

  // regwrite and destination of each shadow stage, shifted every clock
  logic [STAGES:0]                vld_pipe;
  logic [STAGES:0][REG_BITS-1:0]  dst_pipe;
  logic [REG_BITS-1:0]            idex_rs, idex_rt;
  logic                           idex_mr;
  logic [CNT_BITS-1:0]            cnt_q;
  logic                           take;

  // A stalled or flushed ID instruction does not advance; a bubble goes in.
  assign take  = id_valid & ~stall & ~flush;

  // rt is compared even for instructions that do not read it (conservative).
  assign stall = id_valid & idex_mr & (dst_pipe[0] != '0) &
                 ((dst_pipe[0] == id_rs) | (dst_pipe[0] == id_rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dst_pipe <= '0;
      idex_rs  <= '0;
      idex_rt  <= '0;
      idex_mr  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], take & id_regwrite};
      dst_pipe <= {dst_pipe[STAGES-1:0], (take ? id_dst : {REG_BITS{1'b0}})};
      idex_rs  <= take ? id_rs : '0;
      idex_rt  <= take ? id_rt : '0;
      idex_mr  <= take & id_memread;
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_count = cnt_q;

  // operand 0 = A (rs), operand 1 = B (rt)
  logic [1:0][REG_BITS-1:0] opr;
  logic [1:0][1:0]          sel;

  assign opr = {idex_rt, idex_rs};

  for (genvar g = 0; g < 2; g++) begin : g_op
    fwd_select #(.REG_BITS(REG_BITS)) u_sel (
      .opr       (opr[g]),
      .exmem_dst (dst_pipe[1]),
      .exmem_rw  (vld_pipe[1]),
      .memwb_dst (dst_pipe[2]),
      .memwb_rw  (vld_pipe[2]),
      .sel       (sel[g])
    );
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Pipeline forwarding and load-use hazard controller for the 5-stage MIPS core; it produces the 2-bit select codes consumed by the 3-input operand muxes in EX. It keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB destination fields, advanced every clock, rather than sampling the datapath pipeline registers. It drives `fwd_a` and `fwd_b` for the instruction currently in EX, and raises `stall` for a load-use dependency detected in ID.

## Interface
- `REG_BITS`, default 5: width of a register specifier.
- `CNT_BITS`, default 16: width of the stall statistics counter.

Ports:
- `clk`: input, 1 bit. The single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `id_valid`: input, 1 bit. The ID stage holds a real instruction.
- `id_rs`: input, REG_BITS. rs field of the instruction in ID.
- `id_rt`: input, REG_BITS. rt field of the instruction in ID.
- `id_dst`: input, REG_BITS. Final destination after RegDst/link selection.
- `id_regwrite`: input, 1 bit. The instruction in ID writes the register file.
- `id_memread`: input, 1 bit. The instruction in ID is a load.
- `flush`: input, 1 bit. Kill the instruction in ID (taken branch or jump); a bubble enters EX.
- `fwd_a`: output, 2 bits. Select for EX operand A. 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
- `fwd_b`: output, 2 bits. Select for EX operand B, same encoding as `fwd_a`.
- `stall`: output, 1 bit. Hold PC and IF/ID, and insert a bubble into EX.
- `stall_count`: output, CNT_BITS. Saturating count of stall cycles since reset.

## Operation
- Shadow state:
  - IDEX holds {rs, rt, dst, regwrite, memread}.
  - EXMEM holds {dst, regwrite}.
  - MEMWB holds {dst, regwrite}.
- Every rising edge: MEMWB ← EXMEM, and EXMEM ← {IDEX.dst, IDEX.regwrite}.
- IDEX update on the same edge:
  - Captures the ID fields when `id_valid & ~stall & ~flush`.
  - Otherwise it loads a bubble: regwrite=0, memread=0, rs=rt=dst=0.
- Forward select (`fwd_a` uses IDEX.rs, `fwd_b` uses IDEX.rt), evaluated combinationally from shadow state. Priority, first match wins:
  - 10 if EXMEM.regwrite, EXMEM.dst≠0 and EXMEM.dst == the operand register.
  - 01 if MEMWB.regwrite, MEMWB.dst≠0 and MEMWB.dst == the operand register.
  - 00 otherwise.
  - Code 11 is never driven.
- Register $0 never forwards, even when a writer targets it.
- `stall` = `id_valid & IDEX.memread & (IDEX.dst≠0) & (IDEX.dst==id_rs | IDEX.dst==id_rt)`, combinational.
  - It cannot last more than one cycle per load, because the next IDEX is a bubble.
  - It does not check whether the ID instruction actually reads rt. This is conservative and accepted.
- `flush` and `stall` asserted together: IDEX loads a bubble, `stall` stays asserted as computed, and the counter still increments.
- `stall_count` increments on each edge where `stall`=1 and holds at all-ones once saturated.
- Same-cycle WB→ID reads are not this block's concern; the register file is write-through.

## Timing
- Reset values (asynchronous, immediate on `rst`): all shadow regwrite/memread = 0 and all fields = 0. Consequently `fwd_a`=`fwd_b`=00, `stall`=0, `stall_count`=0.
- `rst` asserted mid-operation discards all in-flight shadow entries. The first cycle after release is hazard-free.
- Outputs are combinational from registered state plus ID inputs, with no added latency:
  - `fwd_*` is valid in the cycle the consumer occupies EX.
  - `stall` is valid in the cycle the dependent instruction occupies ID.
- Producer distance in cycles:
  - Distance 1 (back-to-back ALU ops) → code 10.
  - Distance 2 → code 01.
  - Distance 3 and beyond → code 00.
  - Load followed by its consumer → 1 stall cycle, then code 01 once the consumer reaches EX.

## Structure
- Shared package `mips_pkg`:
  - Constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10.
  - Shadow-entry struct typedef.
  - REG_BITS default.
- Sub-module `fwd_select`: the per-operand priority compare. Inputs are the operand register, the EXMEM entry and the MEMWB entry; output is the 2-bit code. Instantiated twice, for A and B.
- The top level holds the shadow registers, stall logic and counter.

## Test plan
- After reset, run `add $3,$1,$2` then `sub $4,$3,$5`. Required: `fwd_a`=10 and `fwd_b`=00 in the sub's EX cycle, and `stall`=0 throughout.
- Run `add $3,…`, then an independent instruction, then `or $6,$7,$3`. Required: `fwd_b`=01 in the or's EX cycle.
- Run `lw $8,0($1)` then `add $9,$8,$8`. Required: exactly one cycle with `stall`=1, `stall_count` goes to 1, then `fwd_a`=`fwd_b`=01 in the add's EX cycle.
- Two writers to $3 at distances 1 and 2, followed by a reader of $3. Required: code 10, showing EXMEM wins. A separate case writes $0 and reads $0; required: code 00.
- `lw $8` in EX while `flush`=1 with a dependent instruction in ID. Required: `stall`=1, the bubble enters EX, and the next cycle shows `stall`=0 with no forward.
- Assert `rst` mid-sequence with a forwarding hazard pending. Required: outputs clear to 00/0/0 immediately, before any clock edge. Separately, force `stall_count` to saturation; required: it stays at 16'hFFFF.
